// File: rtl/chunk_store.sv
// chunk_store: RAM-backed CHUNK_WIDTH^3 voxel store with a fixed 2-cycle tagged
// read pipeline, single-cycle writes, and a clear engine that fills the RAM with
// FILL_VALUE after reset (optional) and on command.
module chunk_store #(
    parameter int    CHUNK_WIDTH    = 16,
    parameter int    BLOCK_BITS     = 5,
    parameter int    COORD_BITS     = 8,
    parameter int    TAG_BITS       = 4,
    parameter int    FILL_VALUE     = 0,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "chunk.mem"
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [COORD_BITS-1:0] rd_x_in,
    input  logic [COORD_BITS-1:0] rd_y_in,
    input  logic [COORD_BITS-1:0] rd_z_in,
    input  logic [TAG_BITS-1:0]   rd_tag_in,
    input  logic                  rd_valid_in,
    output logic                  rd_ready_out,
    input  logic [COORD_BITS-1:0] wr_x_in,
    input  logic [COORD_BITS-1:0] wr_y_in,
    input  logic [COORD_BITS-1:0] wr_z_in,
    input  logic [BLOCK_BITS-1:0] wr_data_in,
    input  logic                  wr_valid_in,
    output logic                  wr_ready_out,
    input  logic                  clear_in,
    output logic                  busy_out,
    output logic [BLOCK_BITS-1:0] rd_data_out,
    output logic [TAG_BITS-1:0]   rd_tag_out,
    output logic                  rd_oob_out,
    output logic                  rd_valid_out
);

    localparam int AW    = $clog2(CHUNK_WIDTH);
    localparam int IW    = 3 * AW;
    localparam int DEPTH = 1 << IW;

    localparam logic [IW-1:0]         LAST_IDX = '1;
    localparam logic [COORD_BITS-1:0] W_C      = COORD_BITS'(CHUNK_WIDTH);
    localparam logic [BLOCK_BITS-1:0] FILL     = BLOCK_BITS'(FILL_VALUE);

    // Without a preload image there is nothing worth keeping, so clear anyway.
    localparam bit DO_RESET_CLEAR = (CLEAR_ON_RESET != 0) || (INIT_FILE == "");

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_clr_idx, w_clr_idx_nxt;
    logic            r_busy;
    logic            r_start_pend;

    logic            w_idle;
    logic            w_rd_acc, w_wr_acc;
    logic            w_rd_inb, w_wr_inb;
    logic [IW-1:0]   w_rd_idx, w_wr_idx;

    logic [BLOCK_BITS-1:0] r_mem [DEPTH];

    logic                  r_p1_valid, r_p2_valid, r_out_valid;
    logic [TAG_BITS-1:0]   r_p1_tag, r_p2_tag, r_out_tag;
    logic                  r_p1_oob, r_p2_oob, r_out_oob;
    logic [BLOCK_BITS-1:0] r_p1_data, r_p2_data, r_out_data;

    // Signed bounds test: sign bit clear and magnitude below the edge length.
    function automatic logic in_bounds(input logic [COORD_BITS-1:0] c);
        return !c[COORD_BITS-1] && (c < W_C);
    endfunction

    assign w_rd_inb = in_bounds(rd_x_in) && in_bounds(rd_y_in) && in_bounds(rd_z_in);
    assign w_wr_inb = in_bounds(wr_x_in) && in_bounds(wr_y_in) && in_bounds(wr_z_in);

    // W is a power of two, so z*W^2 + y*W + x is a plain bit concatenation.
    assign w_rd_idx = {rd_z_in[AW-1:0], rd_y_in[AW-1:0], rd_x_in[AW-1:0]};
    assign w_wr_idx = {wr_z_in[AW-1:0], wr_y_in[AW-1:0], wr_x_in[AW-1:0]};

    // Ports stay closed in reset and in the launch cycle of a post-reset clear.
    assign w_idle       = (r_state == S_IDLE) && rst_in && !r_start_pend;
    assign wr_ready_out = w_idle;
    assign rd_ready_out = w_idle && !wr_valid_in;
    assign w_wr_acc     = wr_valid_in && wr_ready_out;
    assign w_rd_acc     = rd_valid_in && rd_ready_out;

    // Next-state logic for the clear engine.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            S_IDLE: begin
                if (r_start_pend || clear_in) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            S_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // State register, clear counter, registered busy flag and reset-clear request.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_clr_idx    <= '0;
            r_busy       <= 1'b0;
            r_start_pend <= DO_RESET_CLEAR;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_idx    <= w_clr_idx_nxt;
            r_busy       <= (w_state_nxt == S_CLEAR);
            r_start_pend <= 1'b0;
        end
    end

    // RAM write port; the rst_in term keeps a reset edge landing mid-clear from writing.
    always_ff @(posedge clk_in) begin
        if (rst_in && (r_state == S_CLEAR)) begin
            r_mem[r_clr_idx] <= FILL;
        end else if (w_wr_acc && w_wr_inb) begin
            r_mem[w_wr_idx] <= wr_data_in;
        end
    end

    // Read pipeline: RAM sampled at acceptance, then two register stages to the output.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_p1_valid  <= 1'b0;
            r_p1_tag    <= '0;
            r_p1_oob    <= 1'b0;
            r_p1_data   <= '0;
            r_p2_valid  <= 1'b0;
            r_p2_tag    <= '0;
            r_p2_oob    <= 1'b0;
            r_p2_data   <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_oob   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_p1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_p1_tag  <= rd_tag_in;
                r_p1_oob  <= !w_rd_inb;
                r_p1_data <= w_rd_inb ? r_mem[w_rd_idx] : FILL;
            end
            r_p2_valid <= r_p1_valid;
            if (r_p1_valid) begin
                r_p2_tag  <= r_p1_tag;
                r_p2_oob  <= r_p1_oob;
                r_p2_data <= r_p1_data;
            end
            r_out_valid <= r_p2_valid;
            if (r_p2_valid) begin
                r_out_tag  <= r_p2_tag;
                r_out_oob  <= r_p2_oob;
                r_out_data <= r_p2_data;
            end
        end
    end

    assign busy_out     = r_busy;
    assign rd_valid_out = r_out_valid;
    assign rd_data_out  = r_out_data;
    assign rd_tag_out   = r_out_tag;
    assign rd_oob_out   = r_out_oob;

endmodule

// File: tb/tb_chunk_store.sv
// tb_chunk_store: scoreboard bench for chunk_store at W=4 with clear on reset.
// Reads push their expected result when accepted; the output monitor pops and compares.
module tb_chunk_store;

    localparam int W    = 4;
    localparam int N    = W * W * W;
    localparam int BB   = 5;
    localparam int CB   = 8;
    localparam int TAGB = 4;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [CB-1:0]   rd_x_in, rd_y_in, rd_z_in;
    logic [TAGB-1:0] rd_tag_in;
    logic            rd_valid_in;
    logic            rd_ready_out;
    logic [CB-1:0]   wr_x_in, wr_y_in, wr_z_in;
    logic [BB-1:0]   wr_data_in;
    logic            wr_valid_in;
    logic            wr_ready_out;
    logic            clear_in;
    logic            busy_out;
    logic [BB-1:0]   rd_data_out;
    logic [TAGB-1:0] rd_tag_out;
    logic            rd_oob_out;
    logic            rd_valid_out;

    chunk_store #(
        .CHUNK_WIDTH    (W),
        .BLOCK_BITS     (BB),
        .COORD_BITS     (CB),
        .TAG_BITS       (TAGB),
        .FILL_VALUE     (0),
        .CLEAR_ON_RESET (1),
        .INIT_FILE      ("chunk.mem")
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rd_x_in      (rd_x_in),
        .rd_y_in      (rd_y_in),
        .rd_z_in      (rd_z_in),
        .rd_tag_in    (rd_tag_in),
        .rd_valid_in  (rd_valid_in),
        .rd_ready_out (rd_ready_out),
        .wr_x_in      (wr_x_in),
        .wr_y_in      (wr_y_in),
        .wr_z_in      (wr_z_in),
        .wr_data_in   (wr_data_in),
        .wr_valid_in  (wr_valid_in),
        .wr_ready_out (wr_ready_out),
        .clear_in     (clear_in),
        .busy_out     (busy_out),
        .rd_data_out  (rd_data_out),
        .rd_tag_out   (rd_tag_out),
        .rd_oob_out   (rd_oob_out),
        .rd_valid_out (rd_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int data;
        int tag;
        int oob;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   model [N];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_bad   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit inb(input int x, input int y, input int z);
        return x >= 0 && x < W && y >= 0 && y < W && z >= 0 && z < W;
    endfunction

    function automatic int fidx(input int x, input int y, input int z);
        return z * W * W + y * W + x;
    endfunction

    // Output monitor: every pulse must match the oldest outstanding read.
    always @(negedge clk_in) begin
        exp_t e;
        if (rd_valid_out) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", int'(rd_valid_out), 0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", int'(rd_data_out), e.data);
                chk("rd_tag",  int'(rd_tag_out),  e.tag);
                chk("rd_oob",  int'(rd_oob_out),  e.oob);
                chk("rd_lat",  cyc,               e.cyc);
            end
        end
    end

    // One cycle of stimulus, starting 1 time unit after a falling edge.
    task automatic step(input bit rd, input int rx, input int ry, input int rz, input int rtag,
                        input bit wr, input int wx, input int wy, input int wz, input int wd,
                        input bit clr, output bit rd_acc, output bit wr_acc);
        exp_t e;
        rd_valid_in = rd;
        rd_x_in     = CB'(rx);
        rd_y_in     = CB'(ry);
        rd_z_in     = CB'(rz);
        rd_tag_in   = TAGB'(rtag);
        wr_valid_in = wr;
        wr_x_in     = CB'(wx);
        wr_y_in     = CB'(wy);
        wr_z_in     = CB'(wz);
        wr_data_in  = BB'(wd);
        clear_in    = clr;
        #3;
        rd_acc = rd && rd_ready_out;
        wr_acc = wr && wr_ready_out;
        if (wr_acc && inb(wx, wy, wz)) model[fidx(wx, wy, wz)] = wd;
        if (rd_acc) begin
            e.data = inb(rx, ry, rz) ? model[fidx(rx, ry, rz)] : 0;
            e.tag  = rtag;
            e.oob  = inb(rx, ry, rz) ? 0 : 1;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
        @(negedge clk_in);
        #1;
        rd_valid_in = 1'b0;
        wr_valid_in = 1'b0;
        clear_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        bit ra, wa;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra, wa);
    endtask

    task automatic rd(input int x, input int y, input int z, input int tag);
        bit ra, wa;
        step(1, x, y, z, tag, 0, 0, 0, 0, 0, 0, ra, wa);
        chk("rd_accept", int'(ra), 1);
    endtask

    task automatic wr(input int x, input int y, input int z, input int d);
        bit ra, wa;
        step(0, 0, 0, 0, 0, 1, x, y, z, d, 0, ra, wa);
        chk("wr_accept", int'(wa), 1);
    endtask

    task automatic rd_all(input int exp_tag_base);
        for (int i = 0; i < N; i++) rd(i % W, (i / W) % W, i / (W * W), (exp_tag_base + i) % 16);
        idle(4);
    endtask

    // Counts busy cycles of one clear run and checks ports stay closed during it.
    task automatic measure_clear(input string nm);
        int n = 0;
        bit seen = 0;
        bit rdy_bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (busy_out) begin
                n++;
                seen = 1;
                if (rd_ready_out || wr_ready_out) rdy_bad = 1;
            end else if (seen) begin
                break;
            end
        end
        #1;
        chk({nm, "_len"}, n, N);
        chk({nm, "_rdy_low"}, int'(rdy_bad), 0);
        chk({nm, "_rdy_after"}, int'(rd_ready_out), 1);
        for (int i = 0; i < N; i++) model[i] = 0;
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_busy"},  int'(busy_out),     0);
        chk({nm, "_vld"},   int'(rd_valid_out), 0);
        chk({nm, "_data"},  int'(rd_data_out),  0);
        chk({nm, "_tag"},   int'(rd_tag_out),   0);
        chk({nm, "_oob"},   int'(rd_oob_out),   0);
        chk({nm, "_rrdy"},  int'(rd_ready_out), 0);
        chk({nm, "_wrdy"},  int'(wr_ready_out), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ra, wa;
        int n;
        rst_in      = 1'b0;
        rd_valid_in = 1'b0;
        wr_valid_in = 1'b0;
        clear_in    = 1'b0;
        rd_x_in = '0; rd_y_in = '0; rd_z_in = '0; rd_tag_in = '0;
        wr_x_in = '0; wr_y_in = '0; wr_z_in = '0; wr_data_in = '0;
        for (int i = 0; i < N; i++) model[i] = 0;

        @(negedge clk_in);
        #1;
        idle(3);
        reset_checks("rst0");

        // Post-reset clear, then a corner read.
        rst_in = 1'b1;
        measure_clear("clr_boot");
        rd(3, 3, 3, 1);
        idle(3);

        // Write then read on the very next cycle.
        wr(1, 2, 3, 7);
        rd(1, 2, 3, 5);
        idle(3);

        // Back-to-back reads, tags 0..3.
        wr(0, 0, 0, 3);
        wr(1, 0, 0, 4);
        wr(2, 0, 0, 11);
        wr(3, 3, 3, 31);
        rd(0, 0, 0, 0);
        rd(1, 0, 0, 1);
        rd(2, 0, 0, 2);
        rd(3, 3, 3, 3);
        idle(3);

        // Out-of-bounds reads and a discarded out-of-bounds write.
        rd(-1, 0, 0, 8);
        rd(4, 0, 0, 9);
        wr(0, 0, 4, 21);
        wr(0, -2, 1, 22);
        idle(3);
        rd_all(0);

        // Simultaneous write and read: write wins, read goes next cycle and sees it.
        step(1, 2, 2, 2, 10, 1, 2, 2, 2, 13, 0, ra, wa);
        chk("sim_rd_blocked", int'(ra), 0);
        chk("sim_wr_accept",  int'(wa), 1);
        rd(2, 2, 2, 10);
        idle(3);

        // In-flight reads dropped by reset, clear reruns after release.
        rd(2, 2, 2, 11);
        rd(1, 2, 3, 12);
        rst_in = 1'b0;
        sb.delete();
        idle(3);
        reset_checks("rst1");
        rst_in = 1'b1;
        measure_clear("clr_rst1");
        rd(2, 2, 2, 13);
        idle(3);

        // Fill with 9, read+clear together, then reset at clear cycle 10.
        for (int i = 0; i < N; i++) wr(i % W, (i / W) % W, i / (W * W), 9);
        step(1, 2, 1, 0, 6, 0, 0, 0, 0, 0, 1, ra, wa);
        chk("clr_rd_accept", int'(ra), 1);
        n = busy_out ? 1 : 0;
        for (int i = 0; i < 100 && n < 10; i++) begin
            @(negedge clk_in);
            if (busy_out) n++;
        end
        #1;
        chk("clr_mid_count", n, 10);
        rst_in = 1'b0;
        sb.delete();
        idle(2);
        reset_checks("rst2");
        rst_in = 1'b1;
        measure_clear("clr_restart");
        rd_all(3);

        idle(4);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/chunk_store.md
# chunk_store

Parametrised, read/write, RAM-backed voxel chunk store; next generation of the ROM-only chunk (L3) block. Holds `CHUNK_WIDTH`³ block types, serves one tagged read per cycle with a fixed 2-cycle latency, and accepts single-cycle writes. A built-in clear engine fills the store with `FILL_VALUE` on reset and on command. Sits below the L2 cache as the backing store for world edits.

## Interface
- `CHUNK_WIDTH`, 16: edge length in blocks; power of two, 2..32.
- `BLOCK_BITS`, 5: width of a block type.
- `COORD_BITS`, 8: signed width of each coordinate.
- `TAG_BITS`, 4: opaque request tag, returned with the read data.
- `FILL_VALUE`, 0: value written by clear and returned for out-of-bounds reads.
- `CLEAR_ON_RESET`, 1: 1 = run clear after reset; 0 = keep RAM contents (`INIT_FILE` image).
- `INIT_FILE`, "chunk.mem": RAM initial image.
- `clk_in` in 1: clock; sole clock domain.
- `rst_in` in 1: reset, synchronous, active-low.
- `rd_x_in`, `rd_y_in`, `rd_z_in` in `COORD_BITS` each: signed read coordinate.
- `rd_tag_in` in `TAG_BITS`: read tag.
- `rd_valid_in` in 1: read request.
- `rd_ready_out` out 1: read accepted when high together with `rd_valid_in`.
- `wr_x_in`, `wr_y_in`, `wr_z_in` in `COORD_BITS` each: signed write coordinate.
- `wr_data_in` in `BLOCK_BITS`: write data.
- `wr_valid_in` in 1: write request.
- `wr_ready_out` out 1: write accepted when high together with `wr_valid_in`.
- `clear_in` in 1: single-cycle request to start a clear.
- `busy_out` out 1: high while a clear runs.
- `rd_data_out` out `BLOCK_BITS`: read result.
- `rd_tag_out` out `TAG_BITS`: tag of the result.
- `rd_oob_out` out 1: result came from an out-of-bounds coordinate.
- `rd_valid_out` out 1: one-cycle pulse per completed read; no backpressure.

## Operation
- Bounds: a coordinate is in bounds iff 0 ≤ c < `CHUNK_WIDTH`, compared as signed on all three axes. Flat index = z·W² + y·W + x, width log2(W³) bits; computed only from in-bounds values, never truncated from signed products.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR when `clear_in` is high in IDLE, or on the first cycle after reset deassertion if `CLEAR_ON_RESET`=1.
  - CLEAR: writes `FILL_VALUE` to index 0, 1, …, W³−1, one per cycle; → IDLE after index W³−1 is written. `clear_in` during CLEAR is ignored; no restart.
- `wr_ready_out` = (state == IDLE). `rd_ready_out` = (state == IDLE) && !`wr_valid_in`: a write has priority over a read in the same cycle.
- Accepted in-bounds write updates the RAM at the accepting edge. Accepted out-of-bounds write is consumed and discarded; RAM is unchanged.
- Accepted out-of-bounds read does not access the RAM. It returns `FILL_VALUE` with `rd_oob_out`=1 and the same latency as an in-bounds read.
- Read-after-write: a read accepted in the cycle after a write to the same index returns the new data.
- `clear_in` in the same cycle as an accepted read or write: that access completes normally, and CLEAR starts on the next cycle. Reads already in flight return pre-clear data.

## Timing
- Read latency is fixed at 2. A read accepted at edge k produces `rd_valid_out`=1 with its data, tag and oob flag for exactly the cycle following edge k+2.
- Throughput is 1 read per cycle. Up to 2 reads are in flight, and results return in acceptance order.
- Clear duration is exactly W³ cycles of `busy_out`=1. `busy_out` is registered: it rises the cycle after the triggering edge and falls the cycle after the last fill write.
- Reset values while `rst_in`=0: state IDLE, `busy_out`=0, `rd_valid_out`=0, `rd_data_out`=0, `rd_tag_out`=0, `rd_oob_out`=0, `rd_ready_out`=0, `wr_ready_out`=0, clear counter 0.
- Reset mid-operation:
  - In-flight reads are dropped and produce no `rd_valid_out`.
  - A running clear is aborted. If `CLEAR_ON_RESET`=1, it restarts from index 0 after release.
  - Reset alone never alters RAM contents.

## Test plan
- W=4, `CLEAR_ON_RESET`=1. Release reset → `busy_out` high for exactly 64 cycles, ready outputs low throughout. Afterwards, reading (3,3,3) returns 0, oob=0.
- Write 7 to (1,2,3), then read (1,2,3) with tag 5 on the next cycle → `rd_valid_out` 2 cycles after acceptance, data 7, tag 5, oob 0.
- Back-to-back reads on 4 consecutive cycles with tags 0–3 → 4 consecutive `rd_valid_out` pulses, tags in order 0,1,2,3, `rd_ready_out` held high.
- Read (−1,0,0) and (4,0,0) → data `FILL_VALUE`, oob 1, latency 2. Write to (0,0,4) → accepted, and RAM is unchanged, checked by reading all 64 entries.
- Simultaneous `wr_valid_in` and `rd_valid_in` → `rd_ready_out`=0 that cycle, write lands, and the read is accepted next cycle.
- Write 9 everywhere, pulse `clear_in`, then assert `rst_in`=0 at clear cycle 10 → no `rd_valid_out` from reads in flight, and the clear restarts for 64 cycles after release. All entries then read 0.
